// File: rtl/cp0_excpt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_excpt_pkg
//  Description : CP0 register numbers, exception encodings and field positions
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_excpt_pkg;

    localparam logic [4:0] c_cp0_count   = 5'd9;
    localparam logic [4:0] c_cp0_compare = 5'd11;
    localparam logic [4:0] c_cp0_status  = 5'd12;
    localparam logic [4:0] c_cp0_cause   = 5'd13;
    localparam logic [4:0] c_cp0_epc     = 5'd14;

    localparam logic [31:0] c_exc_none    = 32'h0000_0000;
    localparam logic [31:0] c_exc_timer   = 32'h0000_0004;
    localparam logic [31:0] c_exc_syscall = 32'h0000_0100;
    localparam logic [31:0] c_exc_eret    = 32'h0000_0200;

    localparam logic [4:0] c_exccode_int = 5'd0;
    localparam logic [4:0] c_exccode_sys = 5'd8;

    localparam int c_status_ie     = 0;
    localparam int c_status_exl    = 1;
    localparam int c_cause_ip7     = 15;
    localparam int c_cause_exc_lsb = 2;
    localparam int c_excpt_syscall = 8;
    localparam int c_excpt_eret    = 9;

    function automatic logic [31:0] cause_word(input logic ip7, input logic [4:0] code);
        logic [31:0] w;
        w = '0;
        w[c_cause_ip7] = ip7;
        w[c_cause_exc_lsb +: 5] = code;
        return w;
    endfunction

    function automatic logic [31:0] status_word(input logic ie, input logic exl);
        logic [31:0] w;
        w = '0;
        w[c_status_ie]  = ie;
        w[c_status_exl] = exl;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_excpt_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer
//  Description : Prescaled Count, Compare and the IP7 timer-pending flag
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ip7_o
);
    localparam logic [7:0] c_div_last = 8'(COUNT_DIV - 1);

    logic [7:0]  r_presc;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ip7;
    logic        w_match;

    assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc   <= 8'd0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ip7     <= 1'b0;
        end else begin
            // A Count load also restarts the prescaler phase.
            if (count_we_i) begin
                r_count <= wdata_i;
                r_presc <= 8'd0;
            end else if (r_presc == c_div_last) begin
                r_count <= r_count + 32'd1;
                r_presc <= 8'd0;
            end else begin
                r_presc <= r_presc + 8'd1;
            end

            if (compare_we_i) begin
                r_compare <= wdata_i;
                r_ip7     <= 1'b0;
            end else if (w_match) begin
                r_ip7 <= 1'b1;
            end
        end
    end

    assign count_o   = r_count;
    assign compare_o = r_compare;
    assign ip7_o     = r_ip7;

endmodule
`default_nettype wire

// File: rtl/cp0_excpt.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_excpt
//  Description : MEM-stage CP0 registers, timer interrupt and exception encode
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_excpt
    import cp0_excpt_pkg::*;
#(
    parameter int unsigned COUNT_DIV  = 1,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excpt_i,
    input  logic        inst_valid_i,
    input  logic [31:0] pc_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] excptype_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);
    logic        r_ie;
    logic        r_exl;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ip7;
    logic        w_timer_int;
    logic        w_take;
    logic        w_wr;
    logic [31:0] w_excptype;
    logic [31:0] w_rdata;
    logic        w_unused_excpt;

    assign w_unused_excpt = ^{excpt_i[31:10], excpt_i[7:0]};

    assign w_timer_int = inst_valid_i & r_ie & ~r_exl & w_ip7;

    always_comb begin
        w_excptype = c_exc_none;
        if (!rst || !inst_valid_i)
            w_excptype = c_exc_none;
        else if (w_timer_int)
            w_excptype = c_exc_timer;
        else if (excpt_i[c_excpt_syscall])
            w_excptype = c_exc_syscall;
        else if (excpt_i[c_excpt_eret])
            w_excptype = c_exc_eret;
    end

    // The faulting instruction is flushed, so its own mtc0 must not land.
    assign w_take = (w_excptype == c_exc_timer) || (w_excptype == c_exc_syscall);
    assign w_wr   = we_i & ~w_take;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (w_wr && (waddr_i == c_cp0_count)),
        .compare_we_i (w_wr && (waddr_i == c_cp0_compare)),
        .wdata_i      (wdata_i),
        .count_o      (w_count),
        .compare_o    (w_compare),
        .ip7_o        (w_ip7)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ie      <= STATUS_RST[c_status_ie];
            r_exl     <= STATUS_RST[c_status_exl];
            r_exccode <= c_exccode_int;
            r_epc     <= 32'd0;
        end else if (w_take) begin
            r_epc     <= pc_i;
            r_exl     <= 1'b1;
            r_exccode <= (w_excptype == c_exc_timer) ? c_exccode_int : c_exccode_sys;
        end else begin
            if (w_wr && (waddr_i == c_cp0_status)) begin
                r_ie  <= wdata_i[c_status_ie];
                r_exl <= wdata_i[c_status_exl];
            end
            if (w_wr && (waddr_i == c_cp0_epc))
                r_epc <= wdata_i;
            // Eret leaving exception level overrides a same-cycle Status write.
            if (w_excptype == c_exc_eret)
                r_exl <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (raddr_i)
            c_cp0_count:   w_rdata = w_count;
            c_cp0_compare: w_rdata = w_compare;
            c_cp0_status:  w_rdata = status_word(r_ie, r_exl);
            c_cp0_cause:   w_rdata = cause_word(w_ip7, r_exccode);
            c_cp0_epc:     w_rdata = r_epc;
            default:       w_rdata = 32'd0;
        endcase
    end

    assign rdata_o     = w_rdata;
    assign excptype_o  = w_excptype;
    assign epc_o       = r_epc;
    assign timer_int_o = w_ip7;

endmodule
`default_nettype wire

// File: tb/tb_cp0_excpt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_excpt
//  Description : Scoreboard bench for cp0_excpt at COUNT_DIV 1 and 4
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_excpt;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] excpt_i = '0;
    logic        inst_valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  raddr_i = '0;

    logic [31:0] d_rd  [2];
    logic [31:0] d_exc [2];
    logic [31:0] d_epc [2];
    logic        d_ti  [2];

    always #5 clk = ~clk;

    cp0_excpt #(.COUNT_DIV(1), .STATUS_RST(32'h0000_0000)) dut1 (
        .clk(clk), .rst(rst), .excpt_i(excpt_i), .inst_valid_i(inst_valid_i),
        .pc_i(pc_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(d_rd[0]), .excptype_o(d_exc[0]),
        .epc_o(d_epc[0]), .timer_int_o(d_ti[0])
    );

    cp0_excpt #(.COUNT_DIV(4), .STATUS_RST(32'hFFFF_FFF1)) dut4 (
        .clk(clk), .rst(rst), .excpt_i(excpt_i), .inst_valid_i(inst_valid_i),
        .pc_i(pc_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(d_rd[1]), .excptype_o(d_exc[1]),
        .epc_o(d_epc[1]), .timer_int_o(d_ti[1])
    );

    typedef struct {
        int          k;
        logic [31:0] exc;
        logic [31:0] epc;
        logic [31:0] rd;
        logic        ti;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: Count is derived from the last load value and the
    // number of edges since that load, rather than a prescaler register.
    logic [31:0]     m_base [2];
    longint unsigned m_cyc  [2];
    logic [31:0]     m_cmp  [2];
    logic [31:0]     m_epc  [2];
    logic            m_ie   [2];
    logic            m_exl  [2];
    logic            m_ip7  [2];
    logic [4:0]      m_code [2];

    function automatic longint unsigned div_of(input int k);
        return (k == 0) ? 64'd1 : 64'd4;
    endfunction

    function automatic logic [31:0] m_count(input int k);
        return m_base[k] + 32'(m_cyc[k] / div_of(k));
    endfunction

    function automatic logic [31:0] m_exc(input int k);
        if (!rst || !inst_valid_i)                 return 32'h0;
        if (m_ie[k] && !m_exl[k] && m_ip7[k])      return 32'h4;
        if (excpt_i[8])                            return 32'h100;
        if (excpt_i[9])                            return 32'h200;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_rd(input int k);
        case (raddr_i)
            5'd9:    return m_count(k);
            5'd11:   return m_cmp[k];
            5'd12:   return {30'd0, m_exl[k], m_ie[k]};
            5'd13:   return (32'(m_ip7[k]) << 15) | (32'(m_code[k]) << 2);
            5'd14:   return m_epc[k];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset(input int k);
        m_base[k] = 0; m_cyc[k] = 0; m_cmp[k] = 0; m_epc[k] = 0;
        m_ip7[k] = 0; m_code[k] = 0;
        m_ie[k]  = (k == 1);
        m_exl[k] = 1'b0;
    endtask

    task automatic m_edge(input int k);
        logic [31:0] exc;
        logic        take;
        logic        wr;
        exc  = m_exc(k);
        take = (exc == 32'h4) || (exc == 32'h100);
        wr   = we_i && !take;
        if (wr && waddr_i == 5'd11) begin
            m_cmp[k] = wdata_i;
            m_ip7[k] = 1'b0;
        end else if (m_count(k) == m_cmp[k] && m_cmp[k] != 0) begin
            m_ip7[k] = 1'b1;
        end
        if (wr && waddr_i == 5'd9) begin
            m_base[k] = wdata_i;
            m_cyc[k]  = 0;
        end else begin
            m_cyc[k] = m_cyc[k] + 1;
        end
        if (take) begin
            m_epc[k]  = pc_i;
            m_exl[k]  = 1'b1;
            m_code[k] = (exc == 32'h4) ? 5'd0 : 5'd8;
        end else begin
            if (wr && waddr_i == 5'd12) begin
                m_ie[k]  = wdata_i[0];
                m_exl[k] = wdata_i[1];
            end
            if (wr && waddr_i == 5'd14) m_epc[k] = wdata_i;
            if (exc == 32'h200)         m_exl[k] = 1'b0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.k   = k;
            e.exc = m_exc(k);
            e.epc = m_epc[k];
            e.rd  = m_rd(k);
            e.ti  = m_ip7[k];
            q.push_back(e);
        end
    endtask

    task automatic set_idle(input logic [4:0] ra);
        inst_valid_i = 0; excpt_i = 0; pc_i = 0; we_i = 0;
        waddr_i = 0; wdata_i = 0; raddr_i = ra;
    endtask

    task automatic drive(input logic v, input logic [31:0] ex, input logic [31:0] pc,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra);
        @(posedge clk);
        if (rst) begin m_edge(0); m_edge(1); end
        #1;
        inst_valid_i = v; excpt_i = ex; pc_i = pc; we_i = w;
        waddr_i = wa; wdata_i = wd; raddr_i = ra;
        push_exp();
    endtask

    task automatic idle(input logic [4:0] ra);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, ra);
    endtask

    // Assert reset 1 ns after an edge, hold it with a live syscall on the
    // inputs, then release.
    task automatic do_reset(input int n);
        @(posedge clk);
        if (rst) begin m_edge(0); m_edge(1); end
        #1;
        rst = 1'b0;
        m_reset(0); m_reset(1);
        set_idle(5'd12);
        push_exp();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            inst_valid_i = 1; excpt_i = 32'h100; pc_i = 32'h44;
            raddr_i = (i[0]) ? 5'd12 : 5'd13;
            push_exp();
        end
        @(posedge clk); #1;
        set_idle(5'd9);
        rst = 1'b1;
        push_exp();
    endtask

    task automatic cmp(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s got %h expected %h at %0t", k, name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.k, "excptype", d_exc[e.k], e.exc);
            cmp(e.k, "epc", d_epc[e.k], e.epc);
            cmp(e.k, "rdata", d_rd[e.k], e.rd);
            cmp(e.k, "timer_int", {31'd0, d_ti[e.k]}, {31'd0, e.ti});
        end
    end

    initial begin
        int n;
        m_reset(0); m_reset(1);
        set_idle(5'd12);
        #1 push_exp();
        do_reset(2);
        for (int i = 0; i < 5; i++) idle(5'd9);

        // Timer interrupt
        drive(0, 0, 0, 1, 5'd11, 32'd20, 5'd11);
        drive(0, 0, 0, 1, 5'd12, 32'h1, 5'd12);
        n = 0;
        while (!m_ip7[0] && n < 60) begin idle(5'd13); n++; end
        drive(1, 0, 32'h100, 0, 0, 0, 5'd13);
        idle(5'd14); idle(5'd12); idle(5'd13);

        // Syscall then eret
        drive(1, 32'h100, 32'h200, 0, 0, 0, 5'd14);
        idle(5'd13);
        drive(1, 32'h200, 32'h204, 0, 0, 0, 5'd12);
        idle(5'd12);

        // Priority and masking with IP7 still pending
        drive(1, 32'h100, 32'h500, 0, 0, 0, 5'd13);
        drive(1, 32'h100, 32'h504, 0, 0, 0, 5'd13);
        drive(0, 32'h100, 32'h508, 0, 0, 0, 5'd13);
        drive(1, 32'h200, 32'h50c, 0, 0, 0, 5'd12);

        // Count wrap
        drive(0, 0, 0, 1, 5'd9, 32'hFFFF_FFFF, 5'd9);
        for (int i = 0; i < 5; i++) idle(5'd9);

        // Compare write on the match cycle
        drive(0, 0, 0, 1, 5'd11, 32'h50, 5'd13);
        drive(0, 0, 0, 1, 5'd9, 32'h50, 5'd9);
        drive(0, 0, 0, 1, 5'd11, 32'h60, 5'd13);
        idle(5'd13); idle(5'd13);

        // mtc0 EPC suppressed by a same-cycle syscall
        drive(1, 32'h100, 32'h400, 1, 5'd14, 32'h300, 5'd14);
        idle(5'd14);

        // Prescaler phase restart
        idle(5'd9);
        drive(0, 0, 0, 1, 5'd9, 32'h0, 5'd9);
        for (int i = 0; i < 9; i++) idle(5'd9);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic        v, w;
            logic [31:0] ex, wd;
            logic [4:0]  wa, ra;
            logic [4:0]  regs [6];
            regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 2));
                continue;
            end
            v  = ($urandom_range(0, 99) < 70);
            ex = $urandom & ~32'h300;
            if ($urandom_range(0, 99) < 15) ex[8] = 1'b1;
            if ($urandom_range(0, 99) < 20) ex[9] = 1'b1;
            w  = ($urandom_range(0, 99) < 35);
            wa = regs[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) wa = 5'($urandom);
            case (wa)
                5'd9:    wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                          : 32'($urandom_range(0, 40));
                5'd11:   wd = 32'($urandom_range(0, 60));
                default: wd = $urandom;
            endcase
            ra = regs[$urandom_range(0, 5)];
            drive(v, ex, $urandom, w, wa, wd, ra);
        end

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_excpt.md
Name: cp0_excpt

Overview:
- Coprocessor-0 block in the MEM stage, directly upstream of the exception controller.
- Holds the Count, Compare, Status, Cause and EPC registers and generates the timer interrupt.
- Resolves the MEM-stage raw exception bits and the pending interrupt into one encoded `excptype_o` plus `epc_o`. The controller turns these into a flush and a jump target.
- Serves mfc0 reads and mtc0 writes from the pipeline.

Parameters:
- COUNT_DIV, 1: clock cycles per Count increment (1..255).
- STATUS_RST, 32'h0000_0000: reset value of Status.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- excpt_i  in  32  raw exception bits from MEM; bit8 = syscall, bit9 = eret, other bits ignored
- inst_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
- pc_i  in  32  PC of the MEM-stage instruction
- we_i  in  1  mtc0 write enable
- waddr_i  in  5  mtc0 register number
- wdata_i  in  32  mtc0 data
- raddr_i  in  5  mfc0 register number
- rdata_o  out  32  mfc0 read data (combinational)
- excptype_o  out  32  encoded exception to controller: 0x4 = timerInt, 0x100 = Syscall, 0x200 = Eret, 0 = none
- epc_o  out  32  current EPC register
- timer_int_o  out  1  Cause.IP7 (timer pending), for debug/visibility

Behaviour:
- Registers:
  - Count = 9, Compare = 11, Status = 12, Cause = 13, EPC = 14.
  - Reads of any other number return 0; writes to other numbers are ignored.
- Reset (rst = 0, asynchronous):
  - Count, Compare, Cause, EPC and the prescaler are cleared to 0.
  - Status is set to STATUS_RST.
  - Outputs during reset: excptype_o = 0, epc_o = 0, timer_int_o = 0.
- Status fields: bit0 = IE, bit1 = EXL. Only bits [1:0] are writable; all other bits read 0.
- Cause fields: bit15 = IP7 (timer pending), bits[6:2] = ExcCode (0 = Int, 8 = Sys). Cause is read-only to mtc0.
- Count:
  - A prescaler counts 0..COUNT_DIV-1; Count increments by 1 on the prescaler wrap.
  - Count wraps from 0xFFFF_FFFF to 0.
  - An mtc0 write to Count loads wdata_i and resets the prescaler; it takes precedence over the increment.
- Timer:
  - IP7 is set on the clock edge where Count == Compare and Compare != 0.
  - IP7 stays set until an mtc0 write to Compare.
  - A Compare write in the same cycle as a match clears IP7; the write wins.
- Encoding of excptype_o (combinational), fixed priority:
  1. timerInt = inst_valid_i & IE & !EXL & IP7
  2. Syscall = inst_valid_i & excpt_i[8]
  3. Eret = inst_valid_i & excpt_i[9]
  - Otherwise excptype_o = 0.
- Clock-edge update when excptype_o is timerInt or Syscall:
  - EPC <= pc_i.
  - EXL <= 1.
  - ExcCode <= 0 for timerInt, 8 for Syscall.
  - Any mtc0 in that cycle is suppressed, because the instruction is flushed.
- Clock-edge update when excptype_o is Eret: EXL <= 0; EPC is unchanged.
- epc_o = EPC register. An mtc0 to EPC is visible from the next cycle, so a following eret sees it.
- rdata_o reflects register state before the current edge. There is no write-to-read forwarding within a cycle.
- With inst_valid_i = 0:
  - excptype_o = 0.
  - A pending timer interrupt waits for the next valid instruction.
- A syscall/eret arriving while EXL = 1 is still reported. A syscall while EXL = 1 still overwrites EPC.
- Reset asserted mid-operation aborts all state immediately, with no pending interrupt retained.

Decomposition:
- Shared include (def.v) holds:
  - register numbers CP0_COUNT/COMPARE/STATUS/CAUSE/EPC;
  - excptype encodings EXC_TIMER (0x4), EXC_SYSCALL (0x100), EXC_ERET (0x200);
  - ExcCode values;
  - Status/Cause bit positions.
- One natural sub-module, cp0_timer: prescaler, Count, Compare and IP7 set/clear logic. It exports count, compare and ip7, and takes write strobes.

Test Plan:
- Reset then idle, COUNT_DIV = 1:
  - rst low → all outputs 0, rdata(12) = STATUS_RST.
  - After release, Count reads 5 after 5 edges.
- Timer interrupt:
  - Setup: mtc0 Compare = 20, Status = 0x1.
  - When Count reaches 20 → IP7 = 1 and excptype_o = 0x4 with inst_valid_i = 1, pc_i = 0x100.
  - Next edge → EPC = 0x100, Status = 0x3, ExcCode = 0, excptype_o = 0.
- Syscall then eret:
  - excpt_i = 0x100, pc_i = 0x200 → excptype_o = 0x100; after the edge, EPC = 0x200 and ExcCode = 8.
  - Then excpt_i = 0x200 → excptype_o = 0x200, epc_o = 0x200; EXL clears.
- Priority and masking:
  - IP7 = 1 and excpt_i = 0x100 with IE = 1 → 0x4.
  - Same stimulus with EXL = 1 → 0x100.
  - Same stimulus with inst_valid_i = 0 → 0.
- Boundaries:
  - mtc0 Count = 0xFFFF_FFFF → reads 0 one increment later.
  - Compare write on the match cycle → IP7 stays 0.
  - mtc0 EPC = 0x300 in the same cycle as a syscall at pc 0x400 → EPC = 0x400.
- COUNT_DIV = 4 → Count advances once per 4 clocks; an mtc0 Count write restarts the prescaler phase.
